adc_thermometer_decoder: RTL and testbench

//  Receive-side counterpart of the DAC digital interface: decodes a (possibly rotated)

---
 rtl/dac_interface_pkg.sv | 11 +
 rtl/thermometer_ones_counter.sv | 15 +
 rtl/adc_thermometer_decoder.sv | 88 ++++++++
 tb/tb_adc_thermometer_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_interface_pkg.sv
// dac_interface_pkg: rotation codes and field widths shared by the DAC encoder and ADC decoder
package dac_interface_pkg;
    localparam int ROTATION_WIDTH            = 2;
    localparam int DEFAULT_THERMOMETER_WIDTH = 8;
    typedef enum logic [ROTATION_WIDTH-1:0] {
        ROT_NONE = 2'd0,
        ROT_Q1   = 2'd1,
        ROT_Q2   = 2'd2,
        ROT_Q3   = 2'd3
    } rotation_e;
endpackage

// File: rtl/thermometer_ones_counter.sv
// thermometer_ones_counter: combinational ones count of an L-bit thermometer field
//   code_i   in  L            thermometer code
//   count_o  out clog2(L)+1   number of set bits (0..L)
module thermometer_ones_counter #(
    parameter int L = 256,
    localparam int CW = $clog2(L) + 1
) (
    input  logic [L-1:0]  code_i,
    output logic [CW-1:0] count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < L; i++) count_o = count_o + CW'(code_i[i]);
    end
endmodule

// File: rtl/adc_thermometer_decoder.sv
// adc_thermometer_decoder: rotated thermometer + binary LSBs -> binary word, with bubble detection
//   clk_i, rst_ni (async, active-low), en_i (low flushes valids), valid_i, rotation_i,
//   thermometer_i [L], binary_i [OUTPUT_WIDTH-THERMOMETER_WIDTH], clear_count_i,
//   binary_o, valid_o, overrange_o, bubble_err_o, bubble_count_o (saturating).
//   DEROTATION_EN: when defined, rotation_i undoes the encoder's quarter rotation;
//   otherwise rotation_i is ignored and the field is decoded as received.
module adc_thermometer_decoder
    import dac_interface_pkg::*;
#(
    parameter int OUTPUT_WIDTH      = 10,
    parameter int THERMOMETER_WIDTH = DEFAULT_THERMOMETER_WIDTH,
    parameter int COUNT_WIDTH       = 16,
    localparam int L  = 2 ** THERMOMETER_WIDTH,
    localparam int LW = OUTPUT_WIDTH - THERMOMETER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      valid_i,
    input  logic [ROTATION_WIDTH-1:0] rotation_i,
    input  logic [L-1:0]              thermometer_i,
    input  logic [LW-1:0]             binary_i,
    input  logic                      clear_count_i,
    output logic [OUTPUT_WIDTH-1:0]   binary_o,
    output logic                      valid_o,
    output logic                      overrange_o,
    output logic                      bubble_err_o,
    output logic [COUNT_WIDTH-1:0]    bubble_count_o
);
    logic [L-1:0]               s1_therm, code, thermo_ref;
    logic [LW-1:0]              s1_lsb, s2_lsb;
    logic                       s1_valid, s2_valid, s2_bubble;
    logic [THERMOMETER_WIDTH:0] cnt, s2_c;

`ifdef DEROTATION_EN
    logic [ROTATION_WIDTH-1:0] s1_rot;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) s1_rot <= '0;
        else if (en_i) s1_rot <= rotation_i;
    // right rotation by rot*L/4 taken from the low half of a doubled word
    assign code = L'({s1_therm, s1_therm} >> (int'(s1_rot) * (L / 4)));
`else
    logic unused_rot;
    assign unused_rot = ^rotation_i;
    assign code = s1_therm;
`endif

    thermometer_ones_counter #(.L(L)) u_ones (.code_i(code), .count_o(cnt));

    // a clean code is exactly the low cnt bits set; cnt==L shifts everything out
    assign thermo_ref = ~({L{1'b1}} << cnt);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            s1_therm       <= '0;
            s1_lsb         <= '0;
            s1_valid       <= 1'b0;
            s2_c           <= '0;
            s2_bubble      <= 1'b0;
            s2_lsb         <= '0;
            s2_valid       <= 1'b0;
            binary_o       <= '0;
            valid_o        <= 1'b0;
            overrange_o    <= 1'b0;
            bubble_err_o   <= 1'b0;
            bubble_count_o <= '0;
        end else begin
            s1_valid     <= valid_i & en_i;
            s2_valid     <= s1_valid & en_i;
            valid_o      <= s2_valid & en_i;
            bubble_err_o <= s2_valid & s2_bubble & en_i;
            if (en_i) begin
                s1_therm  <= thermometer_i;
                s1_lsb    <= binary_i;
                s2_c      <= cnt;
                s2_bubble <= code != thermo_ref;
                s2_lsb    <= s1_lsb;
            end
            if (en_i && s2_valid) begin
                overrange_o <= s2_c[THERMOMETER_WIDTH];
                binary_o    <= s2_c[THERMOMETER_WIDTH] ? '1 : {s2_c[THERMOMETER_WIDTH-1:0], s2_lsb};
            end
            // clear beats a coincident increment; the count sticks at all ones
            bubble_count_o <= clear_count_i ? '0 :
                              (en_i & s2_valid & s2_bubble & ~&bubble_count_o) ? bubble_count_o + 1'b1 :
                              bubble_count_o;
        end
endmodule

// File: tb/tb_adc_thermometer_decoder.sv
module tb_adc_thermometer_decoder;
    import dac_interface_pkg::*;

    localparam int OW = 10, L = 256, LW = 2, CW = 16, SW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni, en_i, valid_i, clear_count_i;
    logic [1:0]    rotation_i;
    logic [L-1:0]  thermometer_i;
    logic [LW-1:0] binary_i;
    logic [OW-1:0] binary_o, s_binary_o;
    logic          valid_o, overrange_o, bubble_err_o, s_valid_o, s_overrange_o, s_bubble_err_o;
    logic [CW-1:0] bubble_count_o;
    logic [SW-1:0] s_bubble_count_o;

    always #5 clk_i = ~clk_i;

    adc_thermometer_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .valid_i(valid_i), .rotation_i(rotation_i),
        .thermometer_i(thermometer_i), .binary_i(binary_i), .clear_count_i(clear_count_i),
        .binary_o(binary_o), .valid_o(valid_o), .overrange_o(overrange_o),
        .bubble_err_o(bubble_err_o), .bubble_count_o(bubble_count_o)
    );

    // narrow counter instance so saturation is reachable in a short run
    adc_thermometer_decoder #(.COUNT_WIDTH(SW)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .valid_i(valid_i), .rotation_i(rotation_i),
        .thermometer_i(thermometer_i), .binary_i(binary_i), .clear_count_i(clear_count_i),
        .binary_o(s_binary_o), .valid_o(s_valid_o), .overrange_o(s_overrange_o),
        .bubble_err_o(s_bubble_err_o), .bubble_count_o(s_bubble_count_o)
    );

    typedef struct {
        logic [OW-1:0] bin;
        bit            ovr;
        bit            bub;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, cnt = 0, cnt3 = 0;
    bit   clr_prev = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [L-1:0] thermo(input int c);
        logic [L-1:0] t;
        for (int i = 0; i < L; i++) t[i] = (i < c);
        return t;
    endfunction

    function automatic logic [L-1:0] rotl(input logic [L-1:0] t, input int r);
        logic [L-1:0] o;
        for (int i = 0; i < L; i++) o[(i + r * (L / 4)) % L] = t[i];
        return o;
    endfunction

    function automatic exp_t mk(input logic [OW-1:0] bin, input bit ovr, input bit bub);
        exp_t e;
        e.bin = bin; e.ovr = ovr; e.bub = bub; e.cyc = 0;
        return e;
    endfunction

    // reference: undo rotation by index arithmetic, value = ones count, bubble = not a clean low run
    function automatic exp_t model(input logic [L-1:0] t, input logic [1:0] b, input int r);
        exp_t e;
        logic [L-1:0] code;
        int sh, c;
`ifdef DEROTATION_EN
        sh = r * (L / 4);
`else
        sh = 0;
`endif
        for (int i = 0; i < L; i++) code[i] = t[(i + sh) % L];
        c = $countones(code);
        e.bub = 1'b0;
        for (int i = 0; i < L; i++) if (code[i] != (i < c)) e.bub = 1'b1;
        e.ovr = (c == L);
        e.bin = e.ovr ? '1 : OW'((c << LW) | int'(b));
        e.cyc = 0;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [L-1:0] t, input logic [1:0] b, input logic [1:0] r,
                         input bit clr, input exp_t e);
        valid_i = v; thermometer_i = t; binary_i = b; rotation_i = r; clear_count_i = clr;
        if (v && en_i) begin
            e.cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input bit clr = 1'b0);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, clr, mk('0, 1'b0, 1'b0));
    endtask

    // samples whose output edge has not yet happened are lost when enable drops
    task automatic set_en(input bit e);
        exp_t keep[$];
        en_i = e;
        if (!e) begin
            foreach (q[i]) if (q[i].cyc + 3 <= cyc) keep.push_back(q[i]);
            q = keep;
        end
    endtask

    always @(negedge clk_i) begin : monitor
        bit   eb;
        exp_t e;
        eb = 1'b0;
        if (!rst_ni) begin
            cnt = 0; cnt3 = 0; clr_prev = 1'b0;
        end else begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got valid_o=1 binary_o=%0h expected no output (cycle %0d)", binary_o, cyc);
                end else begin
                    e = q.pop_front();
                    check("binary_o", 32'(binary_o), 32'(e.bin));
                    check("overrange_o", 32'(overrange_o), 32'(e.ovr));
                    check("bubble_err_o", 32'(bubble_err_o), 32'(e.bub));
                    check("latency", 32'(cyc - e.cyc), 32'd3);
                    eb = e.bub;
                end
            end else check("bubble_err_idle", 32'(bubble_err_o), 32'd0);
            while (q.size() > 0 && q[0].cyc + 3 < cyc) begin
                e = q.pop_front();
                tests++; fails++;
                $display("FAIL missing_valid: got no valid_o expected binary_o=%0h issued cycle %0d", e.bin, e.cyc);
            end
            cnt  = clr_prev ? 0 : (eb && cnt < (1 << CW) - 1) ? cnt + 1 : cnt;
            cnt3 = clr_prev ? 0 : (eb && cnt3 < (1 << SW) - 1) ? cnt3 + 1 : cnt3;
            check("bubble_count_o", 32'(bubble_count_o), 32'(cnt));
            check("bubble_count_sat", 32'(s_bubble_count_o), 32'(cnt3));
            clr_prev = clear_count_i;
        end
    end

    initial begin
        logic [L-1:0] t;
        logic [1:0]   b, r;
        bit           v, clr;
        rst_ni = 1'b1; en_i = 1'b0; valid_i = 1'b0; clear_count_i = 1'b0;
        rotation_i = '0; thermometer_i = '0; binary_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_binary_o", 32'(binary_o), 32'd0);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_overrange_o", 32'(overrange_o), 32'd0);
        check("rst_bubble_err_o", 32'(bubble_err_o), 32'd0);
        check("rst_bubble_count_o", 32'(bubble_count_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        en_i = 1'b1;

        drive(1'b1, thermo(169), 2'b01, ROT_NONE, 1'b0, mk(10'h2A5, 1'b0, 1'b0));
        idle(4);
`ifdef DEROTATION_EN
        drive(1'b1, rotl(thermo(169), 1), 2'b01, ROT_Q1, 1'b0, mk(10'h2A5, 1'b0, 1'b0));
        drive(1'b1, rotl(thermo(169), 2), 2'b01, ROT_Q2, 1'b0, mk(10'h2A5, 1'b0, 1'b0));
        drive(1'b1, rotl(thermo(169), 3), 2'b01, ROT_Q3, 1'b0, mk(10'h2A5, 1'b0, 1'b0));
`else
        drive(1'b1, rotl(thermo(169), 1), 2'b01, ROT_Q1, 1'b0, mk(10'h2A5, 1'b0, 1'b1));
`endif
        t = thermo(10);
        t[3] = 1'b0;
        drive(1'b1, t, 2'b00, ROT_NONE, 1'b0, mk({8'd9, 2'b00}, 1'b0, 1'b1));
        drive(1'b1, thermo(256), 2'b10, ROT_NONE, 1'b0, mk(10'h3FF, 1'b1, 1'b0));
        idle(4);

        idle(1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, t, 2'b00, ROT_NONE, 1'b0, mk({8'd9, 2'b00}, 1'b0, 1'b1));
        idle(4);
        check("count_five", 32'(bubble_count_o), 32'd5);
        drive(1'b1, t, 2'b11, ROT_NONE, 1'b0, mk({8'd9, 2'b11}, 1'b0, 1'b1));
        idle(1);
        idle(1, 1'b1);
        idle(3);
        check("count_clear_wins", 32'(bubble_count_o), 32'd0);
        for (int i = 0; i < 10; i++) drive(1'b1, t, 2'b01, ROT_NONE, 1'b0, mk({8'd9, 2'b01}, 1'b0, 1'b1));
        idle(4);
        check("count_ten", 32'(bubble_count_o), 32'd10);
        check("count_saturated", 32'(s_bubble_count_o), 32'd7);

        drive(1'b1, thermo(40), 2'b00, ROT_NONE, 1'b0, mk(10'd160, 1'b0, 1'b0));
        drive(1'b1, thermo(41), 2'b00, ROT_NONE, 1'b0, mk(10'd164, 1'b0, 1'b0));
        set_en(1'b0);
        idle(1);
        check("en_flush_valid_o", 32'(valid_o), 32'd0);
        idle(3);
        set_en(1'b1);
        idle(2);

        drive(1'b1, thermo(50), 2'b00, ROT_NONE, 1'b0, mk(10'd200, 1'b0, 1'b0));
        drive(1'b1, t, 2'b00, ROT_NONE, 1'b0, mk({8'd9, 2'b00}, 1'b0, 1'b1));
        valid_i = 1'b1;
        thermometer_i = thermo(60);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_binary_o", 32'(binary_o), 32'd0);
        check("arst_valid_o", 32'(valid_o), 32'd0);
        check("arst_overrange_o", 32'(overrange_o), 32'd0);
        check("arst_bubble_err_o", 32'(bubble_err_o), 32'd0);
        check("arst_bubble_count_o", 32'(bubble_count_o), 32'd0);
        q.delete();
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(4);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                set_en(1'b0);
                idle($urandom_range(1, 3));
                set_en(1'b1);
            end
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            t   = thermo($urandom_range(0, 256));
            if ($urandom_range(0, 3) == 0) t[$urandom_range(0, L - 1)] ^= 1'b1;
            r   = 2'($urandom_range(0, 3));
            b   = 2'($urandom_range(0, 3));
            t   = rotl(t, int'(r));
            drive(v, t, b, r, clr, model(t, b, int'(r)));
        end
        idle(6);
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
